// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder: single-port data memory responder.                       |
// | It has a valid/ready request channel and a valid/ready response channel, |
// | with a configurable number of wait states.                               |
// | Optional define: DMEM_MISALIGN_TRAP_EN (misaligned accesses return err). |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_func,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int OFF_W  = ADDR_W + 2;
  localparam logic [3:0] C_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [3:0] C_NOP = 4'd0;
  localparam logic [3:0] C_LW  = 4'd1;
  localparam logic [3:0] C_LH  = 4'd2;
  localparam logic [3:0] C_LB  = 4'd3;
  localparam logic [3:0] C_LHU = 4'd4;
  localparam logic [3:0] C_LBU = 4'd5;
  localparam logic [3:0] C_SW  = 4'd6;
  localparam logic [3:0] C_SH  = 4'd7;
  localparam logic [3:0] C_SB  = 4'd8;

  localparam logic [1:0] C_SZ_B = 2'd0;
  localparam logic [1:0] C_SZ_H = 2'd1;
  localparam logic [1:0] C_SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [OFF_W-1:0]   addr_q, addr_d;
  logic [3:0]         func_q, func_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic [OFF_W-1:0]   op_addr;
  logic [3:0]         op_func;
  logic [31:0]        op_wdata;
  logic               is_load, is_store, is_signed;
  logic [1:0]         op_size;
  logic [1:0]         op_off;
  logic               op_err;
  logic [ADDR_W-1:0]  op_idx;
  logic [31:0]        rd_word;
  logic [15:0]        half_v;
  logic [7:0]         byte_v;
  logic [31:0]        load_data;
  logic [3:0]         wr_mask;
  logic [31:0]        wr_data;
  logic               wr_en;
  logic               enter_resp;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:OFF_W];

  // With zero wait states the access completes on the handshake edge itself,
  // so the live request fields are used instead of the captured copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_addr  = req_addr[OFF_W-1:0];
      op_func  = req_func;
      op_wdata = req_wdata;
    end else begin
      op_addr  = addr_q;
      op_func  = func_q;
      op_wdata = wdata_q;
    end
  end

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    op_size   = C_SZ_B;
    case (op_func)
      C_LW:  begin is_load = 1'b1; op_size = C_SZ_W; end
      C_LH:  begin is_load = 1'b1; op_size = C_SZ_H; is_signed = 1'b1; end
      C_LB:  begin is_load = 1'b1; op_size = C_SZ_B; is_signed = 1'b1; end
      C_LHU: begin is_load = 1'b1; op_size = C_SZ_H; end
      C_LBU: begin is_load = 1'b1; op_size = C_SZ_B; end
      C_SW:  begin is_store = 1'b1; op_size = C_SZ_W; end
      C_SH:  begin is_store = 1'b1; op_size = C_SZ_H; end
      C_SB:  begin is_store = 1'b1; op_size = C_SZ_B; end
      C_NOP: ;
      default: ;
    endcase
  end

  always_comb begin
    case (op_size)
      C_SZ_W:  op_off = 2'b00;
      C_SZ_H:  op_off = {op_addr[1], 1'b0};
      default: op_off = op_addr[1:0];
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign op_err = (is_load || is_store) &&
                  (((op_size == C_SZ_H) && op_addr[0]) ||
                   ((op_size == C_SZ_W) && (op_addr[1:0] != 2'b00)));
`else
  assign op_err = 1'b0;
`endif

  assign op_idx  = op_addr[OFF_W-1:2];
  assign rd_word = mem_q[op_idx];
  assign half_v  = op_off[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_v  = rd_word[{op_off, 3'b000} +: 8];

  always_comb begin
    load_data = 32'd0;
    if (is_load && !op_err) begin
      case (op_size)
        C_SZ_W:  load_data = rd_word;
        C_SZ_H:  load_data = {{16{is_signed & half_v[15]}}, half_v};
        default: load_data = {{24{is_signed & byte_v[7]}}, byte_v};
      endcase
    end
  end

  always_comb begin
    case (op_size)
      C_SZ_W: begin
        wr_mask = 4'hF;
        wr_data = op_wdata;
      end
      C_SZ_H: begin
        wr_mask = op_off[1] ? 4'hC : 4'h3;
        wr_data = {2{op_wdata[15:0]}};
      end
      default: begin
        wr_mask = 4'b0001 << op_off;
        wr_data = {4{op_wdata[7:0]}};
      end
    endcase
  end

  // Reset wins over a commit on the same edge, so an aborted store never lands.
  assign wr_en = enter_resp && is_store && !op_err && !rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    func_d     = func_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[OFF_W-1:0];
          func_d  = req_func;
          wdata_d = req_wdata;
          cnt_d   = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == C_WAIT_LAST) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = load_data;
      err_d   = op_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      func_q  <= C_NOP;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      func_q  <= func_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem_q[op_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder: table-driven scoreboard bench for dmem_responder.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;
  localparam int DEPTH = 16;
  localparam int WAITC = 1;

  localparam logic [3:0] F_NOP = 4'd0;
  localparam logic [3:0] F_LW  = 4'd1;
  localparam logic [3:0] F_LH  = 4'd2;
  localparam logic [3:0] F_LB  = 4'd3;
  localparam logic [3:0] F_LHU = 4'd4;
  localparam logic [3:0] F_LBU = 4'd5;
  localparam logic [3:0] F_SW  = 4'd6;
  localparam logic [3:0] F_SH  = 4'd7;
  localparam logic [3:0] F_SB  = 4'd8;
  localparam logic [3:0] F_BAD = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_func;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_func  (req_func),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic [3:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] f, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee);
    vec_t v;
    v.func = f; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Drive a request, wait for the handshake edge, leave time at #1 after it.
  task automatic send_req(input logic [3:0] f, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee, input bit push);
    bit   ok;
    exp_t e;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_func  = f;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: req_ready never seen for addr %h", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      sb.push_back(e);
    end
  endtask

  // Latency counts edges from the handshake to the edge at which the
  // requester first samples rsp_valid high.
  task automatic get_rsp(input string name);
    int   lat;
    exp_t e;
    lat = 1;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check32({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check32({name, " latency"}, 32'(lat), 32'(WAITC + 1));
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got rdata %h", name, rsp_rdata);
    end else begin
      e = sb.pop_front();
      check32({name, " rdata"}, rsp_rdata, e.rdata);
      check32({name, " err"}, 32'(rsp_err), 32'(e.err));
    end
    if (rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    req_func  = F_NOP;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;

    add(F_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    add(F_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    add(F_LB,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    add(F_LBU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
    add(F_LH,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
    add(F_LHU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
    add(F_SB,  32'h11, 32'h55,       32'h0,        1'b0);
    add(F_LW,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0);
    add(F_SH,  32'h12, 32'h1234,     32'h0,        1'b0);
    add(F_LW,  32'h10, 32'h0,        32'h123455EF, 1'b0);
    add(F_NOP, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b0);
    add(F_BAD, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b0);
    add(F_LW,  32'h10, 32'h0,        32'h123455EF, 1'b0);
    add(F_SW,  32'h20, 32'hCAFEF00D, 32'h0,        1'b0);
    add(F_LB,  32'h21, 32'h0,        32'hFFFFFFF0, 1'b0);
    add(F_LHU, 32'h22, 32'h0,        32'h0000CAFE, 1'b0);
    add(F_SW,  32'h10 + 4*DEPTH, 32'hA5A50001, 32'h0, 1'b0);
    add(F_LW,  32'h10, 32'h0,        32'hA5A50001, 1'b0);
    add(F_SW,  32'h30, 32'h01020304, 32'h0,        1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(F_LW,  32'h22, 32'h0,        32'h0,        1'b1);
    add(F_LH,  32'h23, 32'h0,        32'h0,        1'b1);
    add(F_SW,  32'h31, 32'hFFFFFFFF, 32'h0,        1'b1);
    add(F_LW,  32'h30, 32'h0,        32'h01020304, 1'b0);
`else
    add(F_LW,  32'h22, 32'h0,        32'hCAFEF00D, 1'b0);
    add(F_LH,  32'h23, 32'h0,        32'hFFFFCAFE, 1'b0);
    add(F_SW,  32'h31, 32'hFFFFFFFF, 32'h0,        1'b0);
    add(F_LW,  32'h30, 32'h0,        32'hFFFFFFFF, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check32("reset req_ready", 32'(req_ready), 32'd1);
    check32("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check32("reset rsp_rdata", rsp_rdata, 32'd0);
    check32("reset rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      send_req(vecs[i].func, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
      get_rsp($sformatf("vec%0d", i));
    end

    // Response back-pressure with a competing request held on the input.
    rsp_ready = 1'b0;
    send_req(F_LW, 32'h10, 32'h0, 32'hA5A50001, 1'b0, 1'b1);
    get_rsp("stall_first");
    req_valid = 1'b1;
    req_func  = F_LW;
    req_addr  = 32'h20;
    req_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check32($sformatf("stall%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
      check32($sformatf("stall%0d rsp_rdata", c), rsp_rdata, 32'hA5A50001);
      check32($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    send_req(F_LW, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    get_rsp("after_stall");

    // Store aborted by reset while waiting must not reach the array.
    send_req(F_SW, 32'h20, 32'h11112222, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check32("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check32("abort rsp_rdata", rsp_rdata, 32'd0);
    check32("abort rsp_err", 32'(rsp_err), 32'd0);
    check32("abort req_ready", 32'(req_ready), 32'd1);
    send_req(F_LW, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    get_rsp("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d errors so far", n_errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in data array (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait states between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents a load/store.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_func  input  4  load_store_func_code (NOP, LW, LH, LB, LHU, LBU, SW, SH, SB).
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  requester accepts the response.
REQ-012 SHALL have port rsp_rdata  output  32  formatted load data; 0 for stores, NOP and errors.
REQ-013 SHALL have port rsp_err  output  1  misaligned-access error.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; handshake = req_valid && req_ready on a rising edge.
REQ-016 SHALL capture addr/func/wdata on handshake; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 SHALL count WAIT_CYCLES cycles in WAIT, then enter RESP; rsp_valid first high WAIT_CYCLES+1 cycles after handshake.
REQ-018 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_valid && rsp_ready, then return to IDLE (next request accepted the following cycle at earliest).
REQ-019 SHALL index words with req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-020 SHALL commit stores exactly once, on the cycle entering RESP: SW all 4 lanes; SH lane pair addr[1]; SB lane addr[1:0].
REQ-021 SHALL format loads: LW whole word; LH/LHU halfword at addr[1], sign-/zero-extended; LB/LBU byte at addr[1:0], sign-/zero-extended.
REQ-022 SHALL treat NOP as a handshaken no-op: response with rdata=0, err=0, no write.
REQ-023 SHALL return load data reflecting all previously committed stores (no stale read).
REQ-024 SHALL treat func encodings outside the enum as NOP.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE, clear wait counter, drive req_ready=1 from the next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-026 SHALL abort an in-flight request on mid-operation reset; a store not yet committed SHALL NOT write.
REQ-027 SHALL NOT initialise data array contents on reset.

Configuration
REQ-028 SHALL use macro DMEM_MISALIGN_TRAP_EN.
REQ-029 SHALL, when defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, respond with rsp_err=1, rdata=0, no write, same latency.
REQ-030 SHALL, when undefined: force alignment (LW/SW ignore addr[1:0], halfword ops ignore addr[0]); rsp_err tied 0.

Verification
REQ-031 SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after each handshake (WAIT_CYCLES=1).
REQ-032 SHALL cover: after REQ-031 word, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 SHALL cover: SB 0x11 data 0x55 then LW 0x10 -> 0xDEAD55EF; SH 0x12 data 0x1234 then LW 0x10 -> 0x123455EF.
REQ-034 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready 0, second req_valid ignored until release.
REQ-035 SHALL cover: SW 0x20 with rst asserted during WAIT -> subsequent LW 0x20 returns prior contents; outputs 0 cycle after reset.
REQ-036 SHALL cover: LW 0x22 -> with DMEM_MISALIGN_TRAP_EN err=1, rdata=0; without, rdata = word at 0x20, err=0; also SW to 0x10+4*DEPTH_WORDS aliases 0x10.
